// File: rtl/tone_gen_if.sv
// Frequency request handshake and tone outputs of tone_gen.
// The slave side is the tone generator; the master side requests tones and watches the outputs.
interface tone_gen_if;
  logic [7:0] freq_in;
  logic       freq_valid;
  logic       freq_ready;
  logic       wave_out;
  logic [7:0] sample_out;
  logic       active;

  modport master (
    output freq_in, freq_valid,
    input  freq_ready, wave_out, sample_out, active
  );

  modport slave (
    input  freq_in, freq_valid,
    output freq_ready, wave_out, sample_out, active
  );
endinterface

// File: rtl/tone_gen.sv
// Square-wave tone generator with glitch-free half-period updates at wave boundaries.
// Define TONE_GEN_ENVELOPE_EN to add a per-period decaying amplitude envelope.
module tone_gen #(
  parameter int         PRESCALE  = 1,
  parameter logic [7:0] AMPLITUDE = 8'd127
) (
  input logic        clk,
  input logic        rst_n,
  tone_gen_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  state_e      state_q, state_d;
  logic        pendValid_q, pendValid_d;
  logic [7:0]  pendVal_q, pendVal_d;
  logic [7:0]  halfPer_q, halfPer_d;
  logic [7:0]  halfCnt_q, halfCnt_d;
  logic [15:0] presc_q, presc_d;
  logic        wave_q, wave_d;
  logic [7:0]  sample_q, sample_d;

  logic       accept;
  logic       tick;
  logic       boundary;
  logic       pendNonZero;
  logic       pendMute;
  logic       loadTone;
  logic       consume;
  logic [7:0] level;

  assign accept      = bus.freq_valid && !pendValid_q;
  assign tick        = (presc_q == PRESC_MAX);
  assign boundary    = (state_q == RUN) && tick && (halfCnt_q == (halfPer_q - 8'd1));
  assign pendNonZero = pendValid_q && (pendVal_q != 8'd0);
  assign pendMute    = pendValid_q && (pendVal_q == 8'd0);
  assign loadTone    = pendNonZero && ((state_q == IDLE) || boundary);

  always_comb begin
    state_d     = state_q;
    pendValid_d = pendValid_q;
    pendVal_d   = pendVal_q;
    halfPer_d   = halfPer_q;
    halfCnt_d   = halfCnt_q;
    presc_d     = tick ? 16'd0 : (presc_q + 16'd1);
    wave_d      = wave_q;
    consume     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pendValid_q) begin
          consume = 1'b1;
          if (pendNonZero) begin
            state_d   = RUN;
            halfPer_d = pendVal_q;
            halfCnt_d = 8'd0;
            wave_d    = 1'b1;
            presc_d   = 16'd0;
          end
        end
      end
      RUN: begin
        if (boundary) begin
          halfCnt_d = 8'd0;
          if (pendMute) begin
            consume = 1'b1;
            wave_d  = 1'b0;
            state_d = IDLE;
          end else begin
            wave_d = !wave_q;
            if (pendNonZero) begin
              consume   = 1'b1;
              halfPer_d = pendVal_q;
            end
          end
        end else if (tick) begin
          halfCnt_d = halfCnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A value accepted on a boundary edge waits for the next boundary, since
    // accept only happens while the pending slot is empty.
    if (accept) begin
      pendValid_d = 1'b1;
      pendVal_d   = bus.freq_in;
    end else if (consume) begin
      pendValid_d = 1'b0;
    end

    sample_d = wave_d ? level : 8'd0;
  end

`ifdef TONE_GEN_ENVELOPE_EN
  logic [7:0] env_q, env_d;

  // A fresh tone restarts the decay; otherwise each falling edge costs one step.
  always_comb begin
    env_d = env_q;
    if (loadTone) begin
      env_d = AMPLITUDE;
    end else if (boundary && wave_q && (env_q != 8'd0)) begin
      env_d = env_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_q <= 8'd0;
    end else begin
      env_q <= env_d;
    end
  end

  assign level = env_d;
`else
  assign level = loadTone ? AMPLITUDE : AMPLITUDE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pendValid_q <= 1'b0;
      pendVal_q   <= 8'd0;
      halfPer_q   <= 8'd0;
      halfCnt_q   <= 8'd0;
      presc_q     <= 16'd0;
      wave_q      <= 1'b0;
      sample_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      pendValid_q <= pendValid_d;
      pendVal_q   <= pendVal_d;
      halfPer_q   <= halfPer_d;
      halfCnt_q   <= halfCnt_d;
      presc_q     <= presc_d;
      wave_q      <= wave_d;
      sample_q    <= sample_d;
    end
  end

  assign bus.freq_ready = !pendValid_q;
  assign bus.wave_out   = wave_q;
  assign bus.sample_out = sample_q;
  assign bus.active     = (state_q == RUN);

endmodule
